// File: rtl/cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_fill
// Description : Cache line fill engine. On a miss it issues one burst read
//               starting at the critical word. It writes each returned beat
//               into the data RAM in the same cycle, at {line index, offset},
//               with the offset wrapping inside the line. The first beat is
//               also forwarded on critWordData so the requester can restart
//               early.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   fillReq/fillLineIndex/
//   fillBaseAddr                fill request, target line, critical byte addr
//   fillBusy, fillDone          engine active / one-cycle completion pulse
//   critWordValid/critWordData  first returned beat
//   memReadReq/memReadAddr/
//   memReadAck                  burst read request handshake
//   memReadDataValid/
//   memReadData                 returned beats, in wrap order
//   ramWrite*                   data RAM write port
// ============================================================================
module cache_line_fill #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 1024,
    parameter  int LINE_WORDS = 8,
    localparam int AW         = $clog2(DEPTH),
    localparam int OW         = $clog2(LINE_WORDS),
    localparam int BW         = (WIDTH + 7) / 8,
    localparam int IW         = AW - OW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fillReq,
    input  logic [IW-1:0]    fillLineIndex,
    input  logic [31:0]      fillBaseAddr,
    output logic             fillBusy,
    output logic             fillDone,
    output logic             critWordValid,
    output logic [WIDTH-1:0] critWordData,
    output logic             memReadReq,
    output logic [31:0]      memReadAddr,
    input  logic             memReadAck,
    input  logic             memReadDataValid,
    input  logic [WIDTH-1:0] memReadData,
    output logic [AW-1:0]    ramWriteAddress,
    output logic [WIDTH-1:0] ramWriteData,
    output logic             ramWriteEnable,
    output logic [BW-1:0]    ramWriteByteEnable
);

    localparam int BSH = $clog2(BW);
    localparam int CW  = OW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BEAT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic [OW-1:0]    r_off;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      r_addr;

    logic             w_beat;
    logic             w_last;
    logic [31:0]      w_shifted;

    // A beat is only accepted while filling. Gating with rst_n means that a
    // beat arriving in the reset cycle itself does not write the RAM.
    assign w_beat    = (r_state == S_BEAT) && memReadDataValid && rst_n;
    assign w_last    = w_beat && (r_cnt == CW'(LINE_WORDS - 1));
    assign w_shifted = fillBaseAddr >> BSH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && fillReq) begin
                r_idx  <= fillLineIndex;
                r_off  <= w_shifted[OW-1:0];
                r_addr <= w_shifted << BSH;
                r_cnt  <= '0;
            end else if (w_beat) begin
                // Offset is exactly OW bits wide, so the increment wraps
                // within the line and never carries into the index.
                r_off <= r_off + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        fillBusy           = 1'b0;
        fillDone           = 1'b0;
        critWordValid      = 1'b0;
        critWordData       = '0;
        memReadReq         = 1'b0;
        memReadAddr        = '0;
        ramWriteAddress    = '0;
        ramWriteData       = '0;
        ramWriteEnable     = 1'b0;
        ramWriteByteEnable = '0;

        case (r_state)
            S_IDLE: begin
                if (fillReq) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                fillBusy    = 1'b1;
                memReadReq  = 1'b1;
                memReadAddr = r_addr;
                if (memReadAck) begin
                    w_next = S_BEAT;
                end
            end
            S_BEAT: begin
                fillBusy = 1'b1;
                if (w_beat) begin
                    ramWriteEnable     = 1'b1;
                    ramWriteAddress    = {r_idx, r_off};
                    ramWriteData       = memReadData;
                    ramWriteByteEnable = '1;
                    if (r_cnt == '0) begin
                        critWordValid = 1'b1;
                        critWordData  = memReadData;
                    end
                end
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                fillBusy = 1'b1;
                fillDone = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_fill
// Description : Scoreboard bench for cache_line_fill. Stimulus pushes the
//               expected burst address, RAM writes, critical word and done
//               pulse into queues; a negedge monitor pops and compares them
//               whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_fill;

    logic        clk;
    logic        rst_n;
    logic        fillReq;
    logic [6:0]  fillLineIndex;
    logic [31:0] fillBaseAddr;
    logic        fillBusy;
    logic        fillDone;
    logic        critWordValid;
    logic [31:0] critWordData;
    logic        memReadReq;
    logic [31:0] memReadAddr;
    logic        memReadAck;
    logic        memReadDataValid;
    logic [31:0] memReadData;
    logic [9:0]  ramWriteAddress;
    logic [31:0] ramWriteData;
    logic        ramWriteEnable;
    logic [3:0]  ramWriteByteEnable;

    cache_line_fill dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fillReq            (fillReq),
        .fillLineIndex      (fillLineIndex),
        .fillBaseAddr       (fillBaseAddr),
        .fillBusy           (fillBusy),
        .fillDone           (fillDone),
        .critWordValid      (critWordValid),
        .critWordData       (critWordData),
        .memReadReq         (memReadReq),
        .memReadAddr        (memReadAddr),
        .memReadAck         (memReadAck),
        .memReadDataValid   (memReadDataValid),
        .memReadData        (memReadData),
        .ramWriteAddress    (ramWriteAddress),
        .ramWriteData       (ramWriteData),
        .ramWriteEnable     (ramWriteEnable),
        .ramWriteByteEnable (ramWriteByteEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [41:0] wq[$];     // {addr, data}
    logic [31:0] cq[$];     // critical word data
    logic [31:0] aq[$];     // burst start address
    int          dq = 0;    // outstanding done pulses
    logic        prev_we = 1'b0;
    logic        req_seen = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [41:0] w;
        if (ramWriteEnable) begin
            if (wq.size() == 0) begin
                chk("unexpected_write_addr", 64'(ramWriteAddress), 64'h3FF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("write_addr", 64'(ramWriteAddress), 64'(w[41:32]));
                chk("write_data", 64'(ramWriteData), 64'(w[31:0]));
                chk("write_be", 64'(ramWriteByteEnable), 64'hF);
            end
        end
        if (critWordValid) begin
            if (cq.size() == 0) chk("unexpected_crit", 64'(critWordData), 64'hFFFF_FFFF_FFFF);
            else chk("crit_data", 64'(critWordData), 64'(cq.pop_front()));
        end
        if (memReadReq && !req_seen) begin
            if (aq.size() == 0) chk("unexpected_memreq", 64'(memReadAddr), 64'hFFFF_FFFF_FFFF);
            else chk("mem_addr", 64'(memReadAddr), 64'(aq.pop_front()));
        end
        req_seen = memReadReq;
        if (fillDone) begin
            if (dq == 0) begin
                chk("unexpected_done", 64'(fillDone), 64'h0);
            end else begin
                dq--;
                chk("done_after_last_write", 64'(prev_we), 64'h1);
                chk("done_all_written", 64'(wq.size()), 64'h0);
            end
        end
        prev_we = ramWriteEnable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fill. exp_maddr and exp_first are hand-computed; the rest
    // of the write addresses wrap within the line of exp_first.
    task automatic run_fill(input logic [6:0] idx, input logic [31:0] base,
                            input logic [31:0] exp_maddr, input int exp_first,
                            input int ack_dly, input logic [15:0] pat, input int len,
                            input logic [31:0] dseed, input bit repulse);
        int j;
        int a;
        aq.push_back(exp_maddr);
        for (int k = 0; k < 8; k++) begin
            a = (exp_first & ~7) | ((exp_first + k) & 7);
            wq.push_back({10'(a), dseed + 32'(k)});
        end
        cq.push_back(dseed);
        dq++;

        fillReq = 1'b1; fillLineIndex = idx; fillBaseAddr = base;
        tick();
        fillReq = 1'b0; fillLineIndex = '0; fillBaseAddr = '0;
        chk("req_asserted", 64'(memReadReq), 64'h1);
        for (int c = 0; c < ack_dly; c++) tick();
        memReadAck = 1'b1;
        tick();
        memReadAck = 1'b0;
        j = 0;
        for (int i = 0; i < len; i++) begin
            memReadDataValid = pat[i];
            memReadData      = pat[i] ? dseed + 32'(j) : 32'hDEAD_BEEF;
            if (pat[i]) j++;
            if (repulse && i == 2) begin
                fillReq = 1'b1; fillLineIndex = 7'd0; fillBaseAddr = 32'h5000;
            end
            tick();
            fillReq = 1'b0; fillLineIndex = '0; fillBaseAddr = '0;
        end
        memReadDataValid = 1'b0;
        memReadData      = '0;
        for (int c = 0; c < 20; c++) begin
            if (!fillBusy) break;
            tick();
        end
        chk("fill_ends_idle", 64'(fillBusy), 64'h0);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; fillReq = 1'b0; fillLineIndex = '0; fillBaseAddr = '0;
        memReadAck = 1'b0; memReadDataValid = 1'b0; memReadData = '0;
        tick(); tick(); tick();
        chk("rst_busy", 64'(fillBusy), 64'h0);
        chk("rst_done", 64'(fillDone), 64'h0);
        chk("rst_memreq", 64'(memReadReq), 64'h0);
        chk("rst_memaddr", 64'(memReadAddr), 64'h0);
        chk("rst_we", 64'(ramWriteEnable), 64'h0);
        chk("rst_crit", 64'(critWordValid), 64'h0);
        rst_n = 1'b1;
        tick();

        // Aligned fill, ack after 2 cycles, 8 back-to-back beats
        run_fill(7'd5, 32'h1000, 32'h1000, 40, 2, 16'h00FF, 8, 32'hA000_0000, 1'b0);
        // Critical word first, offset 5
        run_fill(7'd3, 32'h1014, 32'h1014, 29, 1, 16'h00FF, 8, 32'hB000_0000, 1'b0);
        // Gapped beats 1,0,0,1,1,0,1,1,1,1,1 with an unaligned byte address
        run_fill(7'd10, 32'h2003, 32'h2000, 80, 0, 16'h07D9, 11, 32'hC000_0000, 1'b0);
        // Top line, offset 7, request re-pulsed during BEAT
        run_fill(7'd127, 32'h201C, 32'h201C, 1023, 0, 16'h00FF, 8, 32'hD000_0000, 1'b1);

        // Reset after the 3rd beat of a fill of idx 9, offset 2
        aq.push_back(32'h3008);
        wq.push_back({10'd74, 32'hE000_0000});
        wq.push_back({10'd75, 32'hE000_0001});
        wq.push_back({10'd76, 32'hE000_0002});
        cq.push_back(32'hE000_0000);
        fillReq = 1'b1; fillLineIndex = 7'd9; fillBaseAddr = 32'h3008;
        tick();
        fillReq = 1'b0;
        memReadAck = 1'b1;
        tick();
        memReadAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            memReadDataValid = 1'b1; memReadData = 32'hE000_0000 + 32'(i);
            tick();
        end
        rst_n = 1'b0;
        memReadData = 32'hE000_0003;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 64'(fillBusy), 64'h0);
        for (int i = 4; i < 8; i++) begin
            memReadData = 32'hE000_0000 + 32'(i);
            tick();
            chk("midrst_no_write", 64'(ramWriteEnable), 64'h0);
        end
        memReadDataValid = 1'b0;
        chk("midrst_writes_consumed", 64'(wq.size()), 64'h0);
        tick();

        run_fill(7'd1, 32'h0000, 32'h0000, 8, 1, 16'h00FF, 8, 32'hF000_0000, 1'b0);

        tick(); tick();
        chk("end_wq_empty", 64'(wq.size()), 64'h0);
        chk("end_cq_empty", 64'(cq.size()), 64'h0);
        chk("end_aq_empty", 64'(aq.size()), 64'h0);
        chk("end_dq_empty", 64'(dq), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 The block SHALL have the following parameters:
- WIDTH, default 32, data word width in bits.
- DEPTH, default 1024, data RAM depth in words.
- LINE_WORDS, default 8, words per cache line, power of two.
- Derived: AW = ceil(log2(DEPTH)), OW = log2(LINE_WORDS), BW = (WIDTH+7)/8, IW = AW-OW.
REQ-002 The block SHALL have one clock, clk; reset is synchronous and active-low, named rst_n.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- fillReq  in  1  start a line fill; sampled in IDLE only.
- fillLineIndex  in  IW  target cache line index.
- fillBaseAddr  in  32  byte address of the missed (critical) word.
- fillBusy  out  1  high in any state other than IDLE.
- fillDone  out  1  one-cycle pulse when the line is complete.
- critWordValid  out  1  one-cycle pulse on the first data beat.
- critWordData  out  WIDTH  data of the first beat; valid while critWordValid is high.
- memReadReq  out  1  burst read request to memory.
- memReadAddr  out  32  burst start address: fillBaseAddr with bits [log2(BW)-1:0] cleared.
- memReadAck  in  1  memory accepts the request.
- memReadDataValid  in  1  a data beat is present.
- memReadData  in  WIDTH  beat data, returned in wrap order starting at the critical word.
- ramWriteAddress  out  AW  write address to the data RAM.
- ramWriteData  out  WIDTH  write data to the data RAM.
- ramWriteEnable  out  1  RAM write strobe.
- ramWriteByteEnable  out  BW  byte enables; all ones whenever ramWriteEnable is high.

Function
REQ-004 FSM states SHALL be IDLE, REQ, BEAT and DONE.
REQ-005 IDLE: when fillReq=1, the block SHALL latch the following and go to REQ next cycle:
- fillLineIndex as idx.
- fillBaseAddr[log2(BW)+OW-1:log2(BW)] as off.
- the aligned address for memReadAddr.
- beat counter cleared to 0.
REQ-006 REQ: memReadReq SHALL be 1 and memReadAddr SHALL be stable; on memReadAck=1, go to BEAT next cycle.
REQ-007 memReadDataValid SHALL be ignored in IDLE, REQ and DONE; no RAM write occurs in those states.
REQ-008 BEAT: in each cycle with memReadDataValid=1, combinationally in the same cycle:
- ramWriteEnable = 1.
- ramWriteAddress = {idx, off}.
- ramWriteData = memReadData.
- ramWriteByteEnable = all ones.
REQ-009 BEAT, per accepted beat: off SHALL increment modulo LINE_WORDS (wrap within the line, never touching idx) and the beat counter SHALL increment.
REQ-010 BEAT, cycles with memReadDataValid=0: no write, and off and the counter SHALL hold.
REQ-011 On the first accepted beat (counter=0), critWordValid SHALL be 1 and critWordData SHALL equal memReadData in the same cycle.
REQ-012 After the beat that brings the counter to LINE_WORDS, the FSM SHALL go to DONE; DONE asserts fillDone for exactly one cycle, then returns to IDLE.
REQ-013 fillReq outside IDLE SHALL be ignored (not queued); a fillReq in the DONE cycle is also ignored.
REQ-014 Write latency SHALL be 0 cycles from beat to RAM write strobe. Minimum fill time is 1 (REQ) + LINE_WORDS + 1 (DONE) cycles after the fillReq cycle.
REQ-015 Outputs SHALL be 0 whenever not driven active per REQ-006/008/011/012.

Reset
REQ-016 While rst_n=0 at a clock edge:
- The FSM SHALL enter IDLE.
- Counter, off, idx and latched address SHALL clear to 0.
- All outputs SHALL be 0 from the following cycle.
REQ-017 Reset mid-fill SHALL abandon the line without further RAM writes; beats arriving afterwards are ignored per REQ-007.

Verification (WIDTH=32, DEPTH=1024, LINE_WORDS=8: AW=10, IW=7)
REQ-018 Aligned fill: fillBaseAddr=0x1000, idx=5, ack after 2 cycles, 8 back-to-back beats D0..D7 -> memReadAddr=0x1000; writes to addresses 40..47 with D0..D7; byte enables 4'hF; fillDone one cycle after the D7 write.
REQ-019 Critical-word-first: fillBaseAddr=0x1014, idx=3 -> memReadAddr=0x1014; write order 29,30,31,24,25,26,27,28; critWordValid with data D0 on the first beat only.
REQ-020 Gapped data: memReadDataValid pattern 1,0,0,1,1,0,1,1,1,1,1 -> exactly 8 writes at consecutive wrapped addresses; none in the 0 cycles; fillDone after the 8th write.
REQ-021 Boundary wrap plus busy request: idx=127, offset 7, fillReq re-pulsed during BEAT -> writes 1023 then 1016..1022; the second request produces no extra memReadReq.
REQ-022 Reset mid-fill: rst_n=0 after the 3rd beat, then 5 further memReadDataValid beats -> no writes after the reset; fillBusy=0. A subsequent fill of idx=1 writes 8..15 correctly.
